ram_cmd_arb_2: RTL

Two-requester arbiter that shares one RAM command/response interface between two independent RAM command sources, such as two axi_ram_wr_rd_if instances or a DMA port plus an AXI port. Arbitration is round-robin and locked for the length of a burst. The block records the originating port of every issued read beat in a route FIFO. It uses that FIFO to steer in-order read responses back to the correct requester. It sits between the per-port AXI-to-RAM interface blocks and a single-port RAM backend.

---
 rtl/ram_cmd_arb_2_if.sv | 36 +++
 rtl/ram_cmd_arb_2.sv | 137 +++++++++++++
 2 files changed

// File: rtl/ram_cmd_arb_2_if.sv
// RAM command/response bundle: one beat-level command channel plus an in-order read response channel.
// The requester side uses the master modport; the RAM side uses the slave modport.
interface ram_cmd_arb_2_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int ID_WIDTH   = 8
);
  logic [ID_WIDTH-1:0]   cmd_id;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wr_data;
  logic [STRB_WIDTH-1:0] cmd_wr_strb;
  logic                  cmd_wr_en;
  logic                  cmd_rd_en;
  logic                  cmd_last;
  logic                  cmd_ready;
  logic [ID_WIDTH-1:0]   rd_resp_id;
  logic [DATA_WIDTH-1:0] rd_resp_data;
  logic                  rd_resp_last;
  logic                  rd_resp_valid;
  logic                  rd_resp_ready;

  modport master (
    output cmd_id, cmd_addr, cmd_wr_data, cmd_wr_strb, cmd_wr_en, cmd_rd_en, cmd_last,
    input  cmd_ready,
    input  rd_resp_id, rd_resp_data, rd_resp_last, rd_resp_valid,
    output rd_resp_ready
  );

  modport slave (
    input  cmd_id, cmd_addr, cmd_wr_data, cmd_wr_strb, cmd_wr_en, cmd_rd_en, cmd_last,
    output cmd_ready,
    output rd_resp_id, rd_resp_data, rd_resp_last, rd_resp_valid,
    input  rd_resp_ready
  );
endinterface

// File: rtl/ram_cmd_arb_2.sv
// Two-port round-robin RAM command arbiter with burst locking; a route FIFO records the
// source port of every issued read beat so in-order responses are steered back to it.
//
// state    | meaning
// UNLOCKED | no burst in progress, round-robin between eligible ports
// LOCKED   | burst in progress, only owner_reg may issue beats
module ram_cmd_arb_2 #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 16,
  parameter int STRB_WIDTH       = DATA_WIDTH/8,
  parameter int ID_WIDTH         = 8,
  parameter int ROUTE_FIFO_DEPTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  ram_cmd_arb_2_if.slave  s0,
  ram_cmd_arb_2_if.slave  s1,
  ram_cmd_arb_2_if.master m
);
  localparam int PTR_W = $clog2(ROUTE_FIFO_DEPTH);
  localparam logic [PTR_W:0] FIFO_FULL = (PTR_W+1)'(ROUTE_FIFO_DEPTH);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_t;

  lock_t                       lock_reg, lock_next;
  logic                        owner_reg, last_grant_reg;
  logic [ROUTE_FIFO_DEPTH-1:0] route_mem;
  logic [PTR_W-1:0]            wr_ptr, rd_ptr;
  logic [PTR_W:0]              count;

  logic fifo_full, fifo_empty, route_head;
  logic elig0, elig1, grant_valid, grant_port, mux_sel;
  logic sel_wr, grant_wr, grant_rd, push, pop;

  logic [ID_WIDTH-1:0]   sel_id;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wr_data;
  logic [STRB_WIDTH-1:0] sel_wr_strb;
  logic                  sel_last;

  // Full uses the registered count only, so a same-cycle pop never admits a read.
  assign fifo_full  = (count == FIFO_FULL);
  assign fifo_empty = (count == '0);
  assign route_head = route_mem[rd_ptr];

  assign elig0 = m.cmd_ready && (s0.cmd_wr_en || (s0.cmd_rd_en && !fifo_full));
  assign elig1 = m.cmd_ready && (s1.cmd_wr_en || (s1.cmd_rd_en && !fifo_full));

  always_comb begin
    grant_valid = 1'b0;
    grant_port  = 1'b0;
    if (lock_reg == LOCKED) begin
      grant_port  = owner_reg;
      grant_valid = owner_reg ? elig1 : elig0;
    end else if (elig0 && elig1) begin
      grant_valid = 1'b1;
      grant_port  = ~last_grant_reg;
    end else if (elig0) begin
      grant_valid = 1'b1;
    end else if (elig1) begin
      grant_valid = 1'b1;
      grant_port  = 1'b1;
    end
  end

  // Idle cycles present port 0 on the command bus so it never floats to X.
  assign mux_sel     = grant_valid & grant_port;
  assign sel_id      = mux_sel ? s1.cmd_id      : s0.cmd_id;
  assign sel_addr    = mux_sel ? s1.cmd_addr    : s0.cmd_addr;
  assign sel_wr_data = mux_sel ? s1.cmd_wr_data : s0.cmd_wr_data;
  assign sel_wr_strb = mux_sel ? s1.cmd_wr_strb : s0.cmd_wr_strb;
  assign sel_last    = mux_sel ? s1.cmd_last    : s0.cmd_last;
  assign sel_wr      = mux_sel ? s1.cmd_wr_en   : s0.cmd_wr_en;

  assign grant_wr = grant_valid & sel_wr;
  assign grant_rd = grant_valid & ~sel_wr;

  always_comb begin
    lock_next = lock_reg;
    if (grant_valid) lock_next = sel_last ? UNLOCKED : LOCKED;
  end

  assign m.cmd_id      = sel_id;
  assign m.cmd_addr    = sel_addr;
  assign m.cmd_wr_data = sel_wr_data;
  assign m.cmd_wr_strb = sel_wr_strb;
  assign m.cmd_last    = sel_last;
  assign m.cmd_wr_en   = grant_wr;
  assign m.cmd_rd_en   = grant_rd;

  assign s0.cmd_ready = grant_valid & ~grant_port;
  assign s1.cmd_ready = grant_valid &  grant_port;

  assign s0.rd_resp_id    = m.rd_resp_id;
  assign s0.rd_resp_data  = m.rd_resp_data;
  assign s0.rd_resp_last  = m.rd_resp_last;
  assign s1.rd_resp_id    = m.rd_resp_id;
  assign s1.rd_resp_data  = m.rd_resp_data;
  assign s1.rd_resp_last  = m.rd_resp_last;
  assign s0.rd_resp_valid = ~fifo_empty & ~route_head & m.rd_resp_valid;
  assign s1.rd_resp_valid = ~fifo_empty &  route_head & m.rd_resp_valid;
  assign m.rd_resp_ready  = ~fifo_empty & (route_head ? s1.rd_resp_ready : s0.rd_resp_ready);

  assign push = grant_rd;
  assign pop  = m.rd_resp_valid & m.rd_resp_ready;

  always_ff @(posedge clk) begin
    if (rst) lock_reg <= UNLOCKED;
    else     lock_reg <= lock_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      route_mem      <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
    end else begin
      if (grant_valid) begin
        owner_reg      <= grant_port;
        last_grant_reg <= grant_port;
      end
      if (push) begin
        route_mem[wr_ptr] <= grant_port;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule
